spin_lattice_sweeper: RTL and testbench

Sequential Metropolis engine for a W×H two-dimensional Ising lattice with periodic boundaries, held in on-chip registers. It generalises the single-site spin update into a parametrised checkerboard sweeper: per cycle it updates one half-row of same-parity sites in parallel, using per-column LFSRs and a loadable acceptance-probability table. It sits between the host load/readback path and any statistics logic, and runs a requested number of full sweeps per start.

---
 rtl/spin_pkg.sv | 31 +++
 rtl/spin_site_update.sv | 30 +++
 rtl/spin_lattice_sweeper.sv | 140 ++++++++++++++
 tb/tb_spin_lattice_sweeper.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spin_pkg.sv
// rtl/spin_pkg.sv - shared types, constants and LFSR helpers for the spin lattice sweeper
package spin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic SPIN_UP   = 1'b1;
  localparam logic SPIN_DOWN = 1'b0;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] SEED_STRIDE       = 16'h9E37;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // An all-zero Galois LFSR would lock up, so a zero column seed is replaced.
  function automatic logic [15:0] column_seed(input logic [15:0] seed, input int col);
    logic [31:0] prod;
    logic [15:0] s;
    prod = 32'(col) * 32'(SEED_STRIDE);
    s    = seed ^ prod[15:0];
    return (s == 16'h0000) ? LFSR_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/spin_site_update.sv
// rtl/spin_site_update.sv - combinational Metropolis flip decision for one lattice site
module spin_site_update #(
  parameter int RAND_W = 12
) (
  input  logic              s,
  input  logic              n_up,
  input  logic              n_dn,
  input  logic              n_lf,
  input  logic              n_rt,
  input  logic [RAND_W-1:0] rnd,
  input  logic [RAND_W-1:0] prob4,
  input  logic [RAND_W-1:0] prob8,
  output logic              new_s
);

  logic [2:0] aligned;
  logic       flip;

  // dE = 4*aligned - 8, so aligned <= 2 means dE <= 0.
  always_comb begin
    aligned = 3'(n_up ~^ s) + 3'(n_dn ~^ s) + 3'(n_lf ~^ s) + 3'(n_rt ~^ s);
    case (aligned)
      3'd3:    flip = (rnd < prob4);
      3'd4:    flip = (rnd < prob8);
      default: flip = 1'b1;
    endcase
    new_s = s ^ flip;
  end

endmodule

// File: rtl/spin_lattice_sweeper.sv
// rtl/spin_lattice_sweeper.sv - checkerboard Metropolis sweeper over a WIDTH x HEIGHT Ising lattice
// Define SPIN_MAG_EN to add the running magnetization output.
module spin_lattice_sweeper
  import spin_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter int RAND_W  = 12,
  parameter int SWEEP_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SWEEP_W-1:0]        num_sweeps,
  input  logic [RAND_W-1:0]         prob4,
  input  logic [RAND_W-1:0]         prob8,
  input  logic [15:0]               seed,
  input  logic                      load_en,
  input  logic [$clog2(HEIGHT)-1:0] load_row,
  input  logic [WIDTH-1:0]          load_data,
  input  logic [$clog2(HEIGHT)-1:0] rd_row,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      busy,
  output logic                      done
`ifdef SPIN_MAG_EN
  ,
  output logic signed [$clog2(WIDTH*HEIGHT+1):0] magnetization
`endif
);

  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   lattice [HEIGHT];
  logic [15:0]        lfsr [WIDTH];
  logic [ROW_W-1:0]   row, row_up, row_dn, wr_row;
  logic [SWEEP_W-1:0] sweep_cnt, sweep_target;
  logic [RAND_W-1:0]  p4_q, p8_q;
  logic [WIDTH-1:0]   upd_row, parity_mask, swept_row, wr_data;
  logic               phase, accept_start, wr_en;

  assign accept_start = (state == ST_IDLE) && start && !load_en;
  assign row_up       = (row == '0) ? LAST_ROW : row - 1'b1;
  assign row_dn       = (row == LAST_ROW) ? '0 : row + 1'b1;
  assign phase        = (state == ST_ODD);

  for (genvar c = 0; c < WIDTH; c++) begin : g_site
    spin_site_update #(.RAND_W(RAND_W)) u_site (
      .s     (lattice[row][c]),
      .n_up  (lattice[row_up][c]),
      .n_dn  (lattice[row_dn][c]),
      .n_lf  (lattice[row][(c + WIDTH - 1) % WIDTH]),
      .n_rt  (lattice[row][(c + 1) % WIDTH]),
      .rnd   (lfsr[c][RAND_W-1:0]),
      .prob4 (p4_q),
      .prob8 (p8_q),
      .new_s (upd_row[c])
    );
    assign parity_mask[c] = ((row[0] ^ ((c % 2) == 1)) == phase);
  end

  assign swept_row = (upd_row & parity_mask) | (lattice[row] & ~parity_mask);

  // Host loads and sweep updates share one lattice write port.
  always_comb begin
    wr_en   = 1'b0;
    wr_row  = row;
    wr_data = swept_row;
    if (state == ST_IDLE && load_en) begin
      wr_en   = 1'b1;
      wr_row  = load_row;
      wr_data = load_data;
    end else if (state == ST_EVEN || state == ST_ODD) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept_start) state_next = (num_sweeps == '0) ? ST_DONE : ST_EVEN;
      ST_EVEN: if (row == LAST_ROW) state_next = ST_ODD;
      ST_ODD:  if (row == LAST_ROW)
                 state_next = (sweep_cnt + 1'b1 == sweep_target) ? ST_DONE : ST_EVEN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_EVEN) || (state == ST_ODD);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < HEIGHT; r++) lattice[r] <= {WIDTH{SPIN_DOWN}};
      for (int c = 0; c < WIDTH; c++) lfsr[c] <= LFSR_DEFAULT_SEED;
      rd_data      <= '0;
      row          <= '0;
      sweep_cnt    <= '0;
      sweep_target <= '0;
      p4_q         <= '0;
      p8_q         <= '0;
    end else begin
      rd_data <= lattice[rd_row];
      if (wr_en) lattice[wr_row] <= wr_data;
      if (accept_start) begin
        sweep_target <= num_sweeps;
        p4_q         <= prob4;
        p8_q         <= prob8;
        row          <= '0;
        sweep_cnt    <= '0;
        for (int c = 0; c < WIDTH; c++) lfsr[c] <= column_seed(seed, c);
      end else if (busy) begin
        for (int c = 0; c < WIDTH; c++) lfsr[c] <= lfsr_next(lfsr[c]);
        row <= row_dn;
        if (phase && row == LAST_ROW) sweep_cnt <= sweep_cnt + 1'b1;
      end
    end
  end

`ifdef SPIN_MAG_EN
  localparam int MAG_W = $clog2(WIDTH*HEIGHT+1) + 1;
  logic signed [MAG_W-1:0] mag_delta;

  always_comb mag_delta = MAG_W'(2 * ($countones(wr_data) - $countones(lattice[wr_row])));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     magnetization <= MAG_W'(-(WIDTH*HEIGHT));
    else if (wr_en) magnetization <= magnetization + mag_delta;
  end
`endif

endmodule

// File: tb/tb_spin_lattice_sweeper.sv
// tb/tb_spin_lattice_sweeper.sv - directed self-checking bench for spin_lattice_sweeper
module tb_spin_lattice_sweeper;

  localparam int W = 8;
  localparam int H = 8;
  typedef logic [7:0] rows_t [H];

  logic        clk = 1'b0;
  logic        rst_n, start, load_en;
  logic [15:0] num_sweeps, seed;
  logic [11:0] prob4, prob8;
  logic [2:0]  load_row, rd_row;
  logic [7:0]  load_data, rd_data;
  logic        busy, done;
`ifdef SPIN_MAG_EN
  logic signed [7:0] magnetization;
`endif

  int errors = 0;
  int checks = 0;
  rows_t model_lat;

  spin_lattice_sweeper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_sweeps(num_sweeps),
    .prob4(prob4), .prob8(prob8), .seed(seed), .load_en(load_en),
    .load_row(load_row), .load_data(load_data), .rd_row(rd_row),
    .rd_data(rd_data), .busy(busy), .done(done)
`ifdef SPIN_MAG_EN
    , .magnetization(magnetization)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_mag(input string tag, input int exp);
`ifdef SPIN_MAG_EN
    check(tag, magnetization, exp);
`endif
  endtask

  task automatic read_row(input int r, output logic [7:0] d);
    @(negedge clk);
    rd_row = 3'(r);
    @(posedge clk);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic check_rows(input string tag, input rows_t exp);
    logic [7:0] d;
    for (int r = 0; r < H; r++) begin
      read_row(r, d);
      check($sformatf("%s_row%0d", tag, r), {24'd0, d}, {24'd0, exp[r]});
    end
  endtask

  task automatic load_rows(input rows_t rows);
    for (int r = 0; r < H; r++) begin
      @(negedge clk);
      load_en = 1'b1; load_row = 3'(r); load_data = rows[r];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run(input int n, input int p4, input int p8, input int sd, input bit interfere,
                     output int cycles, output bit busy_seen);
    @(negedge clk);
    num_sweeps = 16'(n); prob4 = 12'(p4); prob8 = 12'(p8); seed = 16'(sd); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    busy_seen = 1'b0;
    while (done !== 1'b1 && cycles < 2000) begin
      if (busy === 1'b1) busy_seen = 1'b1;
      start   = interfere && cycles == 3;
      load_en = interfere && cycles == 5;
      load_row = 3'd3; load_data = 8'h00;
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    start = 1'b0; load_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 0);
    check("busy_after_done", {31'd0, busy}, 0);
  endtask

  function automatic int pm(input logic b);
    return b ? 1 : -1;
  endfunction

  function automatic int mag_of(input rows_t rows);
    int m = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) m += pm(rows[r][c]);
    return m;
  endfunction

  function automatic void model_run(input int n, input int p4, input int p8, input int sd);
    int lf [W];
    int sp, sum, de, rn;
    logic [7:0] nr;
    for (int c = 0; c < W; c++) begin
      lf[c] = (sd ^ ((c * 'h9E37) & 'hFFFF)) & 'hFFFF;
      if (lf[c] == 0) lf[c] = 'hACE1;
    end
    for (int sw = 0; sw < n; sw++)
      for (int ph = 0; ph < 2; ph++)
        for (int r = 0; r < H; r++) begin
          nr = model_lat[r];
          for (int c = 0; c < W; c++)
            if (((r + c) % 2) == ph) begin
              sp  = pm(model_lat[r][c]);
              sum = pm(model_lat[(r+H-1)%H][c]) + pm(model_lat[(r+1)%H][c])
                  + pm(model_lat[r][(c+W-1)%W]) + pm(model_lat[r][(c+1)%W]);
              de  = 2 * sp * sum;
              rn  = lf[c] & 'hFFF;
              if (de <= 0 || (de == 4 && rn < p4) || (de == 8 && rn < p8)) nr[c] = ~nr[c];
            end
          model_lat[r] = nr;
          for (int c = 0; c < W; c++)
            lf[c] = (lf[c] & 1) ? ((lf[c] >> 1) ^ 'hB400) : (lf[c] >> 1);
        end
  endfunction

  initial begin
    rows_t zeros, ones, af, pat, rnd_init, exp_rows, first_rows;
    int cyc;
    bit bs, done_seen;
    logic [7:0] d;

    for (int r = 0; r < H; r++) begin
      zeros[r] = 8'h00;
      ones[r]  = 8'hFF;
      af[r]    = (r % 2 == 0) ? 8'hAA : 8'h55;
      pat[r]   = 8'(r * 'h11 + 1);
    end
    rnd_init = '{8'h3C, 8'hA5, 8'h0F, 8'h96, 8'h71, 8'hE2, 8'h5B, 8'hC8};

    rst_n = 1'b0; start = 1'b0; load_en = 1'b0; num_sweeps = '0; seed = '0;
    prob4 = '0; prob8 = '0; load_row = '0; load_data = '0; rd_row = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check_mag("reset_mag", -64);
    check_rows("reset", zeros);

    load_rows(ones);
    run(1, 0, 0, 'h0001, 1'b0, cyc, bs);
    check("ferro_latency", cyc, 16);
    check("ferro_busy_seen", {31'd0, bs}, 1);
    check_rows("ferro", ones);
    check_mag("ferro_mag", 64);

    load_rows(af);
    check_mag("af_loaded_mag", 0);
    run(1, 0, 0, 'h0001, 1'b0, cyc, bs);
    check("af_latency", cyc, 16);
    check_rows("af", ones);
    check_mag("af_mag", 64);

    load_rows(pat);
    run(0, 0, 0, 'h0001, 1'b0, cyc, bs);
    check("n0_latency", cyc, 0);
    check("n0_busy_seen", {31'd0, bs}, 0);
    check_rows("n0", pat);

    load_rows(af);
    run(2, 0, 0, 'h0001, 1'b1, cyc, bs);
    check("interfere_latency", cyc, 32);
    check_rows("interfere", ones);

    load_rows(af);
    @(negedge clk);
    num_sweeps = 16'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen = 1'b1;
    end
    check("abort_no_done", {31'd0, done_seen}, 0);
    check_rows("abort", zeros);
    check_mag("abort_mag", -64);

    model_lat = rnd_init;
    model_run(4, 'h800, 'h800, 'h1234);
    exp_rows = model_lat;
    load_rows(rnd_init);
    run(4, 'h800, 'h800, 'h1234, 1'b0, cyc, bs);
    check("rand_latency", cyc, 64);
    check_rows("rand", exp_rows);
    check_mag("rand_mag", mag_of(exp_rows));
    for (int r = 0; r < H; r++) begin
      read_row(r, d);
      first_rows[r] = d;
    end
    load_rows(rnd_init);
    run(4, 'h800, 'h800, 'h1234, 1'b0, cyc, bs);
    check_rows("rand_repeat", first_rows);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
